// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RISC-V load/store width
// codes, FSM state encoding and the width-code legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_supported(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load lane selection and sign/zero extension for one 32-bit
// storage word.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable access latency.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output state_t      dbg_state
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; only one access is
  // ever in flight, so the two channels never overlap.

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        do_access;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_f3;
  logic        in_range;
  logic        misaligned;
  logic        acc_err;
  logic [1:0]  offset;
  logic [3:0]  be;
  logic [31:0] wr_lanes;
  logic [IDX_W-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] load_data;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_f3    <= 3'b000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= WAIT_LOAD;
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_f3    <= req_funct3;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // With zero wait cycles the access happens on the accept edge itself, so the
  // live request fields are used instead of the not-yet-latched copies.
  always_comb begin
    if (state == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_f3    = req_funct3;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_f3    = lat_f3;
    end
  end

  assign do_access = reset && (state_nxt == S_RESP) && (state != S_RESP);
  assign in_range  = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
  assign idx       = acc_addr[IDX_W+1:2];
  assign rd_word   = mem[idx];

  always_comb begin
    misaligned = 1'b0;
    offset     = 2'b00;
    be         = 4'b1111;
    wr_lanes   = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        offset   = acc_addr[1:0];
        be       = 4'b0001 << acc_addr[1:0];
        wr_lanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = acc_addr[0];
        offset     = {acc_addr[1], 1'b0};
        be         = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{acc_wdata[15:0]}};
      end
      default: begin
        misaligned = (acc_addr[1:0] != 2'b00);
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_err = !in_range || !f3_supported(acc_f3, acc_we) || misaligned;
`else
  // Low address bits are simply dropped; the misalignment flag has no effect.
  assign acc_err = !in_range || !f3_supported(acc_f3, acc_we) || (misaligned && 1'b0);
`endif

  dmem_load_align u_align (
    .word   (rd_word),
    .offset (offset),
    .funct3 (acc_f3),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || acc_we) ? 32'h0 : load_data;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array
// reference model of the load/store rules.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int WAITC = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  state_t      dbg_state;

  logic [7:0]  ref_mem [DEPTH*4];
  logic [32:0] exp_q [$];
  int          n_vec;
  int          n_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory as a little-endian byte array; returns {err, rdata}.
  function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [2:0] f3);
    int size;
    logic ok;
    logic [31:0] a;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    ok = (size != 0) && !(we && f3[2]);
    if ((addr >> 2) >= DEPTH) ok = 1'b0;
    if (!ok) return {1'b1, 32'h0};
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((addr % size) != 0) return {1'b1, 32'h0};
    a = addr;
`else
    a = addr - (addr % size);
`endif
    if (we) begin
      for (int k = 0; k < size; k++) ref_mem[a + k] = wdata[8*k +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int k = 0; k < size; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
    return {1'b0, v};
  endfunction

  // driver: one full request/response transaction, holding rsp_ready low for
  // 'hold' cycles while pulsing junk requests that must be ignored
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int hold);
    int lat;
    logic [32:0] exp;
    exp_q.push_back(model_access(we, addr, wdata, f3));
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    rsp_ready  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WAITC + 1);
    exp = exp_q.pop_front();
    check("rdata", rsp_rdata, exp[31:0]);
    check("err", rsp_err, {31'h0, exp[32]});
    for (int h = 0; h < hold; h++) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = $urandom_range(0, DEPTH * 4 - 1);
      req_wdata  = $urandom;
      req_funct3 = F3_W;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_rdata", rsp_rdata, exp[31:0]);
      check("hold_err", rsp_err, {31'h0, exp[32]});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("back_idle", dbg_state, S_IDLE);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_funct3 = 3'b000;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_state", dbg_state, S_IDLE);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom, F3_W, 0);

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, 0);
    do_req(1'b0, 32'h10, 32'h0, F3_W, 0);
    do_req(1'b1, 32'h13, 32'h80, F3_B, 0);
    do_req(1'b0, 32'h13, 32'h0, F3_B, 0);
    do_req(1'b0, 32'h13, 32'h0, F3_BU, 0);
    do_req(1'b0, 32'h10, 32'h0, F3_W, 0);
    do_req(1'b0, 32'h10, 32'h0, F3_W, 5);
    do_req(1'b0, 32'h12, 32'h0, F3_W, 0);
    do_req(1'b1, 32'(DEPTH * 4), 32'hCAFE_F00D, F3_W, 0);
    do_req(1'b0, 32'h0, 32'h0, F3_W, 0);

    // reset during the wait phase of a store aborts it
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h1234_5678;
    req_funct3 = F3_W;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", dbg_state, S_WAIT);
    reset = 1'b0;
    #1;
    check("abort_state", dbg_state, S_IDLE);
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      check("abort_ready", req_ready, 1);
    end
    check("abort_rdata", rsp_rdata, 32'h0);
    do_req(1'b0, 32'h20, 32'h0, F3_W, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom_range(DEPTH * 4, DEPTH * 4 + 63);
      else a = $urandom_range(0, DEPTH * 4 - 1);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
             $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
